// File: rtl/rr_mux4_pkg.sv
// rr_mux4_pkg: shared types and helpers for the rr_mux4_arb slice.
//   NCH        - number of arbitrated channels (fixed at 4)
//   ch_idx_t   - 2-bit channel index; wraps naturally mod 4
//   state_t    - output register occupancy (IDLE = empty, FULL = holding a word)
//   grant_t    - result of next_grant: found flag plus granted index
//   next_grant - circular first-set search of req starting at ptr
package rr_mux4_pkg;

  localparam int unsigned NCH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  typedef struct packed {
    logic    found;
    ch_idx_t idx;
  } grant_t;

  // Search ptr, ptr+1, ... (mod 4); the first requesting channel wins.
  function automatic grant_t next_grant(input logic [NCH-1:0] req, input ch_idx_t ptr);
    grant_t  g;
    ch_idx_t cand;
    g = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = ptr + ch_idx_t'(i);
      if (!g.found && req[cand]) begin
        g.found = 1'b1;
        g.idx   = cand;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mux4_1.sv
// mux4_1: 4-to-1 selector for 2-bit channels.
//   A, B, C, D - channel inputs (select 0..3)
//   S          - select index
//   O          - selected channel, combinational
module mux4_1 (
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [1:0] C,
  input  logic [1:0] D,
  input  logic [1:0] S,
  output logic [1:0] O
);

  always_comb begin
    O = '0;
    case (S)
      2'd0: O = A;
      2'd1: O = B;
      2'd2: O = C;
      2'd3: O = D;
      default: O = '0;
    endcase
  end

endmodule

// File: rtl/rr_mux4_arb.sv
// rr_mux4_arb: round-robin arbiter over four W-bit channels feeding mux4_1,
// with a registered, valid/ready-handshaked output word.
//   clk, rst       - clock, synchronous active-high reset
//   req[3:0]       - per-channel request (bit0=A .. bit3=D)
//   A, B, C, D     - channel data
//   ack[3:0]       - one-hot, combinational; marks the channel captured this cycle
//   O, S           - registered data word and its source channel index
//   out_valid      - O/S hold a word not yet accepted downstream
//   out_ready      - downstream accepts O when high with out_valid
module rr_mux4_arb
  import rr_mux4_pkg::*;
#(
  parameter int unsigned W   = 2,
  parameter int unsigned NCH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] C,
  input  logic [W-1:0] D,
  output logic [3:0]   ack,
  output logic [W-1:0] O,
  output logic [1:0]   S,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t       r_state;
  ch_idx_t      r_ptr;
  ch_idx_t      r_sel;
  logic [W-1:0] r_data;

  grant_t       w_grant;
  ch_idx_t      w_gnt;
  logic [W-1:0] w_nxt_data;
  logic         w_full;
  logic         w_load;

  assign w_grant = next_grant(req, r_ptr);
  assign w_gnt   = w_grant.idx;
  assign w_full  = (r_state == FULL);

  // A slot is free when empty or when the held word leaves this cycle.
  assign w_load  = (~w_full | out_ready) & (|req) & ~rst;

  assign ack = w_load ? 4'(4'b0001 << w_gnt) : '0;

  mux4_1 u_mux (
    .A (A),
    .B (B),
    .C (C),
    .D (D),
    .S (w_gnt),
    .O (w_nxt_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_state <= FULL;
      r_data  <= w_nxt_data;
      r_sel   <= w_gnt;
      r_ptr   <= w_gnt + 2'd1;
    end else if (w_full && out_ready) begin
      r_state <= IDLE;
    end
  end

  assign O         = r_data;
  assign S         = r_sel;
  assign out_valid = w_full;

endmodule
